miriscv_data_decoder: RTL and testbench

Parametrised data-bus decoder between the miriscv core's data port and N memory-mapped slaves (RAM, peripherals). It replaces the single-region "address < RAM_SIZE" gating with a per-slave base/size map. Each slave receives a base-relative address, and one outstanding transaction is tracked so the response is routed back from the correct slave. Unmapped accesses and slave timeouts get a defined error response, so the core never hangs waiting for rvalid.

---
 rtl/miriscv_data_decoder_if.sv | 35 +++
 rtl/miriscv_data_decoder.sv | 144 ++++++++++++++
 tb/tb_miriscv_data_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_data_decoder_if.sv
// Data-bus bundle between the miriscv core port and the decoder's slave lanes.
// The decoder takes the slave modport; the environment (core + slaves) takes master.
interface miriscv_data_decoder_if #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  logic                         m_req_i;
  logic                         m_we_i;
  logic [DATA_W/8-1:0]          m_be_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_wdata_i;
  logic                         m_gnt_o;
  logic                         m_rvalid_o;
  logic [DATA_W-1:0]            m_rdata_o;
  logic                         m_err_o;
  logic [N_SLAVES-1:0]          s_req_o;
  logic [N_SLAVES-1:0]          s_we_o;
  logic [N_SLAVES*DATA_W/8-1:0] s_be_o;
  logic [N_SLAVES*ADDR_W-1:0]   s_addr_o;
  logic [N_SLAVES*DATA_W-1:0]   s_wdata_o;
  logic [N_SLAVES-1:0]          s_gnt_i;
  logic [N_SLAVES-1:0]          s_rvalid_i;
  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
  );

  modport master (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
  );
endinterface

// File: rtl/miriscv_data_decoder.sv
// Base/size address decoder from the core data port to N slaves, tracking one
// outstanding transaction and answering unmapped accesses and timeouts with errors.
module miriscv_data_decoder #(
  parameter int                         N_SLAVES       = 2,
  parameter int                         ADDR_W         = 32,
  parameter int                         DATA_W         = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {32'h0000_1000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_SIZE     = {32'h0000_0100, 32'h0000_0100},
  parameter int                         TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0]          ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  miriscv_data_decoder_if.slave      bus,
  output logic [15:0]                err_count_o,
  output logic [ADDR_W-1:0]          last_err_addr_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RSP, ERR_RSP} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [TMO_W-1:0]   tmo;
  logic [15:0]        err_count;
  logic [ADDR_W-1:0]  last_err_addr;
  logic [ADDR_W-1:0]  req_addr;
  logic               hit;
  logic [SEL_W-1:0]   hit_idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scan from the top index down so the lowest overlapping region wins.
  always_comb begin
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] size;
    hit     = 1'b0;
    hit_idx = '0;
    base    = '0;
    size    = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      base = SLAVE_BASE[k*ADDR_W +: ADDR_W];
      size = SLAVE_SIZE[k*ADDR_W +: ADDR_W];
      if ((bus.m_addr_i >= base) && ((bus.m_addr_i - base) < size)) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Outputs are combinational so grant and response pass through with no added latency.
  always_comb begin
    bus.m_gnt_o    = 1'b0;
    bus.m_rvalid_o = 1'b0;
    bus.m_rdata_o  = '0;
    bus.m_err_o    = 1'b0;
    bus.s_req_o    = '0;
    bus.s_we_o     = '0;
    bus.s_be_o     = '0;
    bus.s_addr_o   = '0;
    bus.s_wdata_o  = '0;
    if (!rst_i) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        if (hit && (hit_idx == SEL_W'(k))) begin
          bus.s_we_o[k]                  = bus.m_we_i;
          bus.s_be_o[k*BE_W +: BE_W]     = bus.m_be_i;
          bus.s_addr_o[k*ADDR_W +: ADDR_W] = bus.m_addr_i - SLAVE_BASE[k*ADDR_W +: ADDR_W];
          bus.s_wdata_o[k*DATA_W +: DATA_W] = bus.m_wdata_i;
          if (state == IDLE) bus.s_req_o[k] = bus.m_req_i;
        end
      end
      case (state)
        IDLE:     bus.m_gnt_o = hit ? bus.s_gnt_i[hit_idx] : bus.m_req_i;
        WAIT_RSP: begin
          if (bus.s_rvalid_i[sel]) begin
            bus.m_rvalid_o = 1'b1;
            bus.m_rdata_o  = bus.s_rdata_i[sel*DATA_W +: DATA_W];
          end
        end
        ERR_RSP: begin
          bus.m_rvalid_o = 1'b1;
          bus.m_err_o    = 1'b1;
          bus.m_rdata_o  = ERR_RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      sel           <= '0;
      tmo           <= '0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_req_i) begin
            if (!hit) begin
              last_err_addr <= bus.m_addr_i;
              state         <= ERR_RSP;
            end else if (bus.s_gnt_i[hit_idx]) begin
              sel   <= hit_idx;
              tmo   <= '0;
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.s_rvalid_i[sel]) begin
            state <= IDLE;
          end else if (tmo == TMO_LAST) begin
            last_err_addr <= req_addr;
            state         <= ERR_RSP;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ERR_RSP: begin
          err_count <= sat_inc16(err_count);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request address is datapath only; it is reported if the slave times out.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && bus.m_req_i) req_addr <= bus.m_addr_i;
  end

  assign err_count_o     = err_count;
  assign last_err_addr_o = last_err_addr;

endmodule

// File: tb/tb_miriscv_data_decoder.sv
// Directed bench for miriscv_data_decoder: two slaves at 0x0000 and 0x1000, 256 bytes each.
module tb_miriscv_data_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err_count;
  logic [31:0] last_err_addr;
  int          total  = 0;
  int          passed = 0;

  miriscv_data_decoder_if #(.N_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();

  miriscv_data_decoder #(
    .N_SLAVES(2), .ADDR_W(32), .DATA_W(32),
    .SLAVE_BASE({32'h0000_1000, 32'h0000_0000}),
    .SLAVE_SIZE({32'h0000_0100, 32'h0000_0100}),
    .TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .err_count_o(err_count), .last_err_addr_o(last_err_addr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.m_req_i    = 1'b0;
    bus.m_we_i     = 1'b0;
    bus.m_be_i     = 4'h0;
    bus.m_addr_i   = 32'h0;
    bus.m_wdata_i  = 32'h0;
    bus.s_gnt_i    = 2'b00;
    bus.s_rvalid_i = 2'b00;
    bus.s_rdata_i  = 64'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0800;
    @(negedge clk); #1;
    total++; if (bus.m_gnt_o !== 1'b0) $display("FAIL rst_gnt_miss got %b exp 0", bus.m_gnt_o); else passed++;
    total++; if (bus.m_rvalid_o !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", bus.m_rvalid_o); else passed++;
    total++; if (err_count !== 16'd0) $display("FAIL rst_err_count got %0d exp 0", err_count); else passed++;
    total++; if (last_err_addr !== 32'h0) $display("FAIL rst_last_err got %h exp 0", last_err_addr); else passed++;
    bus.m_addr_i = 32'h0000_0010;
    bus.s_gnt_i  = 2'b01;
    #1;
    total++; if (bus.s_req_o !== 2'b00) $display("FAIL rst_s_req got %b exp 00", bus.s_req_o); else passed++;
    total++; if (bus.m_gnt_o !== 1'b0) $display("FAIL rst_gnt_hit got %b exp 0", bus.m_gnt_o); else passed++;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0010;
    bus.m_be_i   = 4'hF;
    bus.s_gnt_i  = 2'b01;
    #1;
    total++; if (bus.s_req_o !== 2'b01) $display("FAIL rd_s_req got %b exp 01", bus.s_req_o); else passed++;
    total++; if (bus.s_addr_o[31:0] !== 32'h10) $display("FAIL rd_s_addr got %h exp 10", bus.s_addr_o[31:0]); else passed++;
    total++; if (bus.m_gnt_o !== 1'b1) $display("FAIL rd_gnt got %b exp 1", bus.m_gnt_o); else passed++;
    total++; if (bus.m_rdata_o !== 32'h0) $display("FAIL rd_rdata_idle got %h exp 0", bus.m_rdata_o); else passed++;
    @(negedge clk);
    idle_inputs();
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'hFFFF_FFFF, 32'h1234_5678};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1) $display("FAIL rd_rvalid got %b exp 1", bus.m_rvalid_o); else passed++;
    total++; if (bus.m_rdata_o !== 32'h1234_5678) $display("FAIL rd_rdata got %h exp 12345678", bus.m_rdata_o); else passed++;
    total++; if (bus.m_err_o !== 1'b0) $display("FAIL rd_err got %b exp 0", bus.m_err_o); else passed++;
    total++; if (bus.m_gnt_o !== 1'b0) $display("FAIL rd_gnt_wait got %b exp 0", bus.m_gnt_o); else passed++;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.m_rvalid_o !== 1'b0) $display("FAIL rd_rvalid_after got %b exp 0", bus.m_rvalid_o); else passed++;
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    bus.m_req_i   = 1'b1;
    bus.m_we_i    = 1'b1;
    bus.m_addr_i  = 32'h0000_1004;
    bus.m_be_i    = 4'b0011;
    bus.m_wdata_i = 32'hA5A5_A5A5;
    bus.s_gnt_i   = 2'b10;
    #1;
    total++; if (bus.s_req_o !== 2'b10) $display("FAIL wr_s_req got %b exp 10", bus.s_req_o); else passed++;
    total++; if (bus.s_addr_o !== {32'h4, 32'h0}) $display("FAIL wr_s_addr got %h exp 0000000400000000", bus.s_addr_o); else passed++;
    total++; if (bus.s_be_o !== 8'b0011_0000) $display("FAIL wr_s_be got %b exp 00110000", bus.s_be_o); else passed++;
    total++; if (bus.s_we_o !== 2'b10) $display("FAIL wr_s_we got %b exp 10", bus.s_we_o); else passed++;
    total++; if (bus.s_wdata_o !== {32'hA5A5_A5A5, 32'h0}) $display("FAIL wr_s_wdata got %h exp a5a5a5a500000000", bus.s_wdata_o); else passed++;
    total++; if (bus.m_gnt_o !== 1'b1) $display("FAIL wr_gnt got %b exp 1", bus.m_gnt_o); else passed++;
    @(negedge clk);
    idle_inputs();
    bus.s_rvalid_i = 2'b10;
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1 || bus.m_err_o !== 1'b0) $display("FAIL wr_done got rvalid=%b err=%b exp rvalid=1 err=0", bus.m_rvalid_o, bus.m_err_o); else passed++;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (err_count !== 16'd0) $display("FAIL wr_err_count got %0d exp 0", err_count); else passed++;
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0800;
    #1;
    total++; if (bus.m_gnt_o !== 1'b1) $display("FAIL um_gnt got %b exp 1", bus.m_gnt_o); else passed++;
    total++; if (bus.s_req_o !== 2'b00) $display("FAIL um_s_req got %b exp 00", bus.s_req_o); else passed++;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1 || bus.m_err_o !== 1'b1) $display("FAIL um_rsp got rvalid=%b err=%b exp 1 1", bus.m_rvalid_o, bus.m_err_o); else passed++;
    total++; if (bus.m_rdata_o !== 32'hDEAD_BEEF) $display("FAIL um_rdata got %h exp deadbeef", bus.m_rdata_o); else passed++;
    @(negedge clk); #1;
    total++; if (err_count !== 16'd1) $display("FAIL um_err_count got %0d exp 1", err_count); else passed++;
    total++; if (last_err_addr !== 32'h800) $display("FAIL um_last_err got %h exp 800", last_err_addr); else passed++;
    total++; if (bus.m_rvalid_o !== 1'b0) $display("FAIL um_rvalid_after got %b exp 0", bus.m_rvalid_o); else passed++;
  endtask

  task automatic test_timeout();
    int rsp_seen = 0;
    int gnt_seen = 0;
    @(negedge clk);
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0020;
    bus.s_gnt_i  = 2'b00;
    #1;
    total++; if (bus.m_gnt_o !== 1'b0) $display("FAIL to_stall_gnt got %b exp 0", bus.m_gnt_o); else passed++;
    @(negedge clk);
    bus.s_gnt_i = 2'b01;
    // 16 wait cycles, with a competing request held to prove no grant is issued
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.m_req_i  = 1'b1;
      bus.m_addr_i = 32'h0000_0030;
      bus.s_gnt_i  = 2'b01;
      #1;
      if (bus.m_rvalid_o) rsp_seen++;
      if (bus.m_gnt_o || bus.s_req_o != 2'b00) gnt_seen++;
    end
    total++; if (rsp_seen != 0) $display("FAIL to_early_rsp got %0d exp 0", rsp_seen); else passed++;
    total++; if (gnt_seen != 0) $display("FAIL to_gnt_in_wait got %0d exp 0", gnt_seen); else passed++;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1 || bus.m_err_o !== 1'b1 || bus.m_rdata_o !== 32'hDEAD_BEEF)
      $display("FAIL to_err_rsp got rvalid=%b err=%b data=%h exp 1 1 deadbeef", bus.m_rvalid_o, bus.m_err_o, bus.m_rdata_o); else passed++;
    @(negedge clk); #1;
    total++; if (err_count !== 16'd2) $display("FAIL to_err_count got %0d exp 2", err_count); else passed++;
    total++; if (last_err_addr !== 32'h20) $display("FAIL to_last_err got %h exp 20", last_err_addr); else passed++;
    @(negedge clk);
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'h0, 32'h5555_AAAA};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b0 || bus.m_rdata_o !== 32'h0) $display("FAIL to_late_rsp got rvalid=%b data=%h exp 0 0", bus.m_rvalid_o, bus.m_rdata_o); else passed++;
    @(negedge clk);
    idle_inputs();
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_1008;
    bus.s_gnt_i  = 2'b10;
    #1;
    total++; if (bus.m_gnt_o !== 1'b1 || bus.s_req_o !== 2'b10) $display("FAIL to_next_req got gnt=%b s_req=%b exp 1 10", bus.m_gnt_o, bus.s_req_o); else passed++;
    @(negedge clk);
    idle_inputs();
    bus.s_rvalid_i = 2'b10;
    bus.s_rdata_i  = {32'h0BAD_F00D, 32'h0};
    #1;
    total++; if (bus.m_rdata_o !== 32'h0BAD_F00D || bus.m_err_o !== 1'b0) $display("FAIL to_next_rsp got data=%h err=%b exp 0badf00d 0", bus.m_rdata_o, bus.m_err_o); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    int rsp_seen = 0;
    @(negedge clk);
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0044;
    bus.s_gnt_i  = 2'b01;
    @(negedge clk);
    rst            = 1'b1;
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'h0, 32'h7777_7777};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b0 || bus.m_rdata_o !== 32'h0) $display("FAIL mr_rsp got rvalid=%b data=%h exp 0 0", bus.m_rvalid_o, bus.m_rdata_o); else passed++;
    total++; if (bus.s_req_o !== 2'b00 || bus.m_gnt_o !== 1'b0) $display("FAIL mr_req got s_req=%b gnt=%b exp 00 0", bus.s_req_o, bus.m_gnt_o); else passed++;
    total++; if (err_count !== 16'd0) $display("FAIL mr_err_count got %0d exp 0", err_count); else passed++;
    @(negedge clk);
    idle_inputs();
    rst            = 1'b0;
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'h0, 32'h7777_7777};
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.m_rvalid_o) rsp_seen++;
      @(negedge clk);
    end
    total++; if (rsp_seen != 0) $display("FAIL mr_dropped got %0d exp 0", rsp_seen); else passed++;
    idle_inputs();
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0014;
    bus.s_gnt_i  = 2'b01;
    @(negedge clk);
    idle_inputs();
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'h0, 32'h0BAD_CAFE};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1 || bus.m_rdata_o !== 32'h0BAD_CAFE) $display("FAIL mr_fresh got rvalid=%b data=%h exp 1 0badcafe", bus.m_rvalid_o, bus.m_rdata_o); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int gnts = 0;
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.m_req_i  = 1'b1;
      bus.m_addr_i = 32'h0000_2000 + 32'(i);
      #1;
      if (bus.m_gnt_o) gnts++;
      @(negedge clk);
      #1;
      if (bus.m_rvalid_o && bus.m_err_o && !bus.m_gnt_o) errs++;
    end
    total++; if (gnts != 300) $display("FAIL b2b_gnts got %0d exp 300", gnts); else passed++;
    total++; if (errs != 300) $display("FAIL b2b_errs got %0d exp 300", errs); else passed++;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (err_count !== 16'd300) $display("FAIL b2b_err_count got %0d exp 300", err_count); else passed++;
    total++; if (last_err_addr !== 32'h0000_212B) $display("FAIL b2b_last_err got %h exp 212b", last_err_addr); else passed++;
  endtask

  task automatic test_stray_rvalid();
    @(negedge clk);
    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h0000_0040;
    bus.s_gnt_i  = 2'b01;
    @(negedge clk);
    idle_inputs();
    bus.s_rvalid_i = 2'b10;
    bus.s_rdata_i  = {32'h0000_0BAD, 32'h0};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b0 || bus.m_rdata_o !== 32'h0) $display("FAIL stray_rsp got rvalid=%b data=%h exp 0 0", bus.m_rvalid_o, bus.m_rdata_o); else passed++;
    @(negedge clk);
    bus.s_rvalid_i = 2'b01;
    bus.s_rdata_i  = {32'h0000_0BAD, 32'hCAFE_F00D};
    #1;
    total++; if (bus.m_rvalid_o !== 1'b1 || bus.m_rdata_o !== 32'hCAFE_F00D || bus.m_err_o !== 1'b0)
      $display("FAIL stray_real got rvalid=%b data=%h err=%b exp 1 cafef00d 0", bus.m_rvalid_o, bus.m_rdata_o, bus.m_err_o); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_unmapped();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_stray_rvalid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
